// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB that allocates tags, captures broadcast results,
// forwards ready operands and retires one entry per cycle with commit/rollback outputs.
module reorder_buffer #(
  parameter int ENTRY_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                new_issue,
  input  logic [1:0]          issue_type,
  input  logic [5:0]          issue_rd,
  input  logic [31:0]         issue_pred_pc,
  output logic [ENTRY_SIZE:0] rob_new_entry,
  output logic                rob_full,
  input  logic                rs_broadcast,
  input  logic [ENTRY_SIZE:0] rs_entry,
  input  logic [31:0]         rs_result,
  input  logic [31:0]         rs_next_pc,
  input  logic                lsb_broadcast,
  input  logic [ENTRY_SIZE:0] lsb_entry,
  input  logic [31:0]         lsb_result,
  input  logic [ENTRY_SIZE:0] query_j,
  input  logic [ENTRY_SIZE:0] query_k,
  output logic                query_j_ready,
  output logic                query_k_ready,
  output logic [31:0]         query_j_value,
  output logic [31:0]         query_k_value,
  output logic                rob_commit,
  output logic [ENTRY_SIZE:0] rob_entry,
  output logic [5:0]          rob_des,
  output logic [31:0]         rob_result,
  output logic                store_commit,
  output logic                roll_back,
  output logic [31:0]         roll_back_pc
);
  localparam int N = 1 << ENTRY_SIZE;
  typedef logic [ENTRY_SIZE-1:0] idx_t;
  typedef logic [ENTRY_SIZE:0] tag_t;
  logic [N-1:0] valid_q, valid_d, ready_q, ready_d;
  logic [1:0]   type_q [N];
  logic [1:0]   type_d [N];
  logic [5:0]   rd_q [N];
  logic [5:0]   rd_d [N];
  logic [31:0]  pred_q [N];
  logic [31:0]  pred_d [N];
  logic [31:0]  npc_q [N];
  logic [31:0]  npc_d [N];
  logic [31:0]  val_q [N];
  logic [31:0]  val_d [N];
  idx_t         head_q, head_d, tail_q, tail_d;
  tag_t         count_q, count_d;
  logic         commit_q, commit_d, store_q, store_d, rb_q, rb_d;
  tag_t         entry_q, entry_d;
  logic [5:0]   des_q, des_d;
  logic [31:0]  result_q, result_d, rb_pc_q, rb_pc_d;
  idx_t         rs_slot, lsb_slot, qj_slot, qk_slot;
  logic         rs_hit, lsb_hit, do_commit, do_issue, mispredict;

  function automatic logic in_range(tag_t t);
    return t != '0 && t <= tag_t'(N);
  endfunction

  assign rs_slot       = idx_t'(rs_entry - tag_t'(1));
  assign lsb_slot      = idx_t'(lsb_entry - tag_t'(1));
  assign qj_slot       = idx_t'(query_j - tag_t'(1));
  assign qk_slot       = idx_t'(query_k - tag_t'(1));
  assign rs_hit        = rs_broadcast && in_range(rs_entry) && valid_q[rs_slot];
  assign lsb_hit       = lsb_broadcast && in_range(lsb_entry) && valid_q[lsb_slot];
  assign rob_full      = count_q == tag_t'(N);
  assign rob_new_entry = tag_t'(tail_q) + tag_t'(1);
  assign do_issue      = new_issue && !rob_full;
  assign do_commit     = valid_q[head_q] && ready_q[head_q];
  assign mispredict    = do_commit && type_q[head_q] == 2'd1 && npc_q[head_q] != pred_q[head_q];
  assign query_j_ready = in_range(query_j) && valid_q[qj_slot] && ready_q[qj_slot];
  assign query_k_ready = in_range(query_k) && valid_q[qk_slot] && ready_q[qk_slot];
  assign query_j_value = query_j_ready ? val_q[qj_slot] : '0;
  assign query_k_value = query_k_ready ? val_q[qk_slot] : '0;
  assign rob_commit    = commit_q;
  assign rob_entry     = entry_q;
  assign rob_des       = des_q;
  assign rob_result    = result_q;
  assign store_commit  = store_q;
  assign roll_back     = rb_q;
  assign roll_back_pc  = rb_pc_q;

  always_comb begin
    valid_d  = valid_q;
    ready_d  = ready_q;
    type_d   = type_q;
    rd_d     = rd_q;
    pred_d   = pred_q;
    npc_d    = npc_q;
    val_d    = val_q;
    head_d   = head_q;
    tail_d   = tail_q;
    commit_d = do_commit;
    store_d  = do_commit && type_q[head_q] == 2'd2;
    rb_d     = mispredict;
    entry_d  = do_commit ? tag_t'(head_q) + tag_t'(1) : entry_q;
    des_d    = do_commit ? (type_q[head_q] == 2'd2 ? 6'd0 : rd_q[head_q]) : des_q;
    result_d = do_commit ? val_q[head_q] : result_q;
    rb_pc_d  = mispredict ? npc_q[head_q] : rb_pc_q;
    if (rs_hit) begin
      val_d[rs_slot]   = rs_result;
      npc_d[rs_slot]   = rs_next_pc;
      ready_d[rs_slot] = 1'b1;
    end
    // LSB applied second so it wins when both buses carry the same tag
    if (lsb_hit) begin
      val_d[lsb_slot]   = lsb_result;
      ready_d[lsb_slot] = 1'b1;
    end
    if (do_commit) begin
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + idx_t'(1);
    end
    // Next PC defaults to the prediction so an LSB-only completion never flushes
    if (do_issue) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      type_d[tail_q]  = issue_type;
      rd_d[tail_q]    = issue_rd;
      pred_d[tail_q]  = issue_pred_pc;
      npc_d[tail_q]   = issue_pred_pc;
      tail_d          = tail_q + idx_t'(1);
    end
    count_d = count_q + tag_t'(do_issue) - tag_t'(do_commit);
    if (mispredict) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      valid_q  <= '0;
      ready_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      commit_q <= 1'b0;
      store_q  <= 1'b0;
      rb_q     <= 1'b0;
      entry_q  <= '0;
      des_q    <= '0;
      result_q <= '0;
      rb_pc_q  <= '0;
    end else if (rdy_in) begin
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      commit_q <= commit_d;
      store_q  <= store_d;
      rb_q     <= rb_d;
      entry_q  <= entry_d;
      des_q    <= des_d;
      result_q <= result_d;
      rb_pc_q  <= rb_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy_in) begin
      type_q <= type_d;
      rd_q   <= rd_d;
      pred_q <= pred_d;
      npc_q  <= npc_d;
      val_q  <= val_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic against a queue-based ROB model.
module tb_reorder_buffer;
  logic clk = 1'b0, rst_in, rdy_in, new_issue;
  logic [1:0] issue_type;
  logic [5:0] issue_rd;
  logic [31:0] issue_pred_pc;
  logic [4:0] rob_new_entry;
  logic rob_full, rs_broadcast, lsb_broadcast;
  logic [4:0] rs_entry, lsb_entry, query_j, query_k;
  logic [31:0] rs_result, rs_next_pc, lsb_result;
  logic query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic rob_commit, store_commit, roll_back;
  logic [4:0] rob_entry;
  logic [5:0] rob_des;
  logic [31:0] rob_result, roll_back_pc;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .new_issue(new_issue), .issue_type(issue_type),
    .issue_rd(issue_rd), .issue_pred_pc(issue_pred_pc), .rob_new_entry(rob_new_entry), .rob_full(rob_full),
    .rs_broadcast(rs_broadcast), .rs_entry(rs_entry), .rs_result(rs_result), .rs_next_pc(rs_next_pc),
    .lsb_broadcast(lsb_broadcast), .lsb_entry(lsb_entry), .lsb_result(lsb_result),
    .query_j(query_j), .query_k(query_k), .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_value(query_j_value), .query_k_value(query_k_value), .rob_commit(rob_commit),
    .rob_entry(rob_entry), .rob_des(rob_des), .rob_result(rob_result), .store_commit(store_commit),
    .roll_back(roll_back), .roll_back_pc(roll_back_pc)
  );

  typedef struct {int tag; int typ; int rd; logic [31:0] pred; logic [31:0] npc; logic [31:0] val; bit rdy;} ent_t;
  ent_t q[$];
  int m_tail;
  bit e_commit, e_store, e_rb;
  logic [4:0] e_entry;
  logic [5:0] e_des;
  logic [31:0] e_result, e_rb_pc;

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; new_issue = 1'b0; issue_type = 2'd0; issue_rd = 6'd0; issue_pred_pc = 32'd0;
    rs_broadcast = 1'b0; rs_entry = 5'd0; rs_result = 32'd0; rs_next_pc = 32'd0;
    lsb_broadcast = 1'b0; lsb_entry = 5'd0; lsb_result = 32'd0; query_j = 5'd0; query_k = 5'd0;
  endtask

  // Advance one clock, updating the in-order queue model from the currently driven inputs.
  task automatic cycle();
    bit do_c, mis;
    int n;
    ent_t e;
    if (rst_in) begin
      q.delete(); m_tail = 0; e_commit = 0; e_store = 0; e_rb = 0;
      e_entry = 0; e_des = 0; e_result = 0; e_rb_pc = 0;
    end else if (rdy_in) begin
      n = q.size();
      do_c = n > 0 && q[0].rdy;
      mis = 0; e_commit = do_c; e_store = 0; e_rb = 0;
      if (do_c) begin
        e_entry = 5'(q[0].tag); e_des = q[0].typ == 2 ? 6'd0 : 6'(q[0].rd); e_result = q[0].val;
        e_store = q[0].typ == 2; mis = q[0].typ == 1 && q[0].npc != q[0].pred; e_rb = mis;
        if (mis) e_rb_pc = q[0].npc;
      end
      foreach (q[i]) begin
        if (rs_broadcast && q[i].tag == int'(rs_entry)) begin q[i].val = rs_result; q[i].npc = rs_next_pc; q[i].rdy = 1; end
        if (lsb_broadcast && q[i].tag == int'(lsb_entry)) begin q[i].val = lsb_result; q[i].rdy = 1; end
      end
      if (do_c) void'(q.pop_front());
      if (new_issue && n < 16) begin
        e.tag = m_tail + 1; e.typ = int'(issue_type); e.rd = int'(issue_rd); e.pred = issue_pred_pc;
        e.npc = issue_pred_pc; e.val = 0; e.rdy = 0;
        q.push_back(e); m_tail = (m_tail + 1) % 16;
      end
      if (mis) begin q.delete(); m_tail = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle(); rst_in = 1'b1; cycle(); rst_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL reset_commit got %0h want 0", rob_commit); end
    checks++; if (store_commit !== 1'b0) begin errors++; $display("FAIL reset_store got %0h want 0", store_commit); end
    checks++; if (roll_back !== 1'b0) begin errors++; $display("FAIL reset_rb got %0h want 0", roll_back); end
    checks++; if ({rob_entry, rob_des, rob_result, roll_back_pc} !== '0) begin errors++; $display("FAIL reset_data got %0h/%0h/%0h/%0h want 0", rob_entry, rob_des, rob_result, roll_back_pc); end
    checks++; if (rob_full !== 1'b0 || rob_new_entry !== 5'd1) begin errors++; $display("FAIL reset_alloc got full %0h tag %0h want 0/1", rob_full, rob_new_entry); end
  endtask

  task automatic test_in_order();
    int bt[3] = '{3, 1, 2};
    logic [31:0] bv[3] = '{32'h30, 32'h10, 32'h20};
    reset_dut();
    for (int i = 0; i < 3; i++) begin idle(); new_issue = 1; issue_rd = 6'(5 + i); cycle(); end
    checks++; if (rob_new_entry !== 5'd4) begin errors++; $display("FAIL order_tag got %0h want 4", rob_new_entry); end
    for (int i = 0; i < 3; i++) begin
      idle(); rs_broadcast = 1; rs_entry = 5'(bt[i]); rs_result = bv[i]; cycle();
      if (i < 2) begin
        checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL order_early%0d got %0h want 0", i, rob_commit); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rob_commit !== 1'b1 || rob_entry !== 5'(i + 1) || rob_des !== 6'(i + 5) || rob_result !== 32'((i + 1) * 16)) begin
        errors++; $display("FAIL order_commit%0d got %0h/%0h/%0h/%0h want 1/%0h/%0h/%0h", i, rob_commit, rob_entry, rob_des, rob_result, i + 1, i + 5, (i + 1) * 16);
      end
      idle(); cycle();
    end
    checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL order_done got %0h want 0", rob_commit); end
  endtask

  task automatic test_full_wrap();
    reset_dut();
    for (int i = 0; i < 16; i++) begin idle(); new_issue = 1; issue_rd = 6'd1; cycle(); end
    checks++; if (rob_full !== 1'b1 || rob_new_entry !== 5'd1) begin errors++; $display("FAIL full_set got %0h/%0h want 1/1", rob_full, rob_new_entry); end
    idle(); new_issue = 1; cycle();
    checks++; if (rob_full !== 1'b1 || rob_new_entry !== 5'd1) begin errors++; $display("FAIL full_ignore got %0h/%0h want 1/1", rob_full, rob_new_entry); end
    idle(); rs_broadcast = 1; rs_entry = 5'd1; rs_result = 32'h77; cycle();
    idle(); new_issue = 1; cycle();
    checks++; if (rob_commit !== 1'b1 || rob_entry !== 5'd1 || rob_full !== 1'b0 || rob_new_entry !== 5'd1) begin
      errors++; $display("FAIL full_commit got %0h/%0h/%0h/%0h want 1/1/0/1", rob_commit, rob_entry, rob_full, rob_new_entry);
    end
    idle(); new_issue = 1; cycle();
    checks++; if (rob_full !== 1'b1 || rob_new_entry !== 5'd2) begin errors++; $display("FAIL full_wrap got %0h/%0h want 1/2", rob_full, rob_new_entry); end
  endtask

  task automatic test_mispredict();
    reset_dut();
    idle(); new_issue = 1; issue_type = 2'd1; issue_rd = 6'd1; issue_pred_pc = 32'h104; cycle();
    idle(); new_issue = 1; issue_rd = 6'd2; cycle();
    idle(); new_issue = 1; issue_rd = 6'd3; cycle();
    idle(); rs_broadcast = 1; rs_entry = 5'd1; rs_result = 32'h108; rs_next_pc = 32'h200;
    lsb_broadcast = 1; lsb_entry = 5'd2; lsb_result = 32'h22; cycle();
    idle(); new_issue = 1; cycle();
    checks++; if (rob_commit !== 1'b1 || roll_back !== 1'b1 || roll_back_pc !== 32'h200) begin
      errors++; $display("FAIL mis_flush got %0h/%0h/%0h want 1/1/200", rob_commit, roll_back, roll_back_pc);
    end
    checks++; if (rob_des !== 6'd1 || rob_result !== 32'h108) begin errors++; $display("FAIL mis_rd got %0h/%0h want 1/108", rob_des, rob_result); end
    checks++; if (rob_new_entry !== 5'd1 || rob_full !== 1'b0) begin errors++; $display("FAIL mis_tail got %0h/%0h want 1/0", rob_new_entry, rob_full); end
    idle(); cycle();
    checks++; if (rob_commit !== 1'b0 || roll_back !== 1'b0 || rob_new_entry !== 5'd1) begin
      errors++; $display("FAIL mis_after got %0h/%0h/%0h want 0/0/1", rob_commit, roll_back, rob_new_entry);
    end
  endtask

  task automatic test_store();
    reset_dut();
    idle(); new_issue = 1; issue_type = 2'd2; cycle();
    idle(); lsb_broadcast = 1; lsb_entry = 5'd1; lsb_result = 32'habc; cycle();
    idle(); cycle();
    checks++; if (rob_commit !== 1'b1 || store_commit !== 1'b1 || rob_entry !== 5'd1 || rob_des !== 6'd0) begin
      errors++; $display("FAIL store_commit got %0h/%0h/%0h/%0h want 1/1/1/0", rob_commit, store_commit, rob_entry, rob_des);
    end
    idle(); cycle();
    checks++; if (store_commit !== 1'b0) begin errors++; $display("FAIL store_pulse got %0h want 0", store_commit); end
  endtask

  task automatic test_rdy_stall();
    reset_dut();
    idle(); new_issue = 1; issue_rd = 6'd4; cycle();
    idle(); rs_broadcast = 1; rs_entry = 5'd1; rs_result = 32'h99; cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy_in = 0; cycle();
      checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL stall%0d got %0h want 0", i, rob_commit); end
    end
    idle(); cycle();
    checks++; if (rob_commit !== 1'b1 || rob_result !== 32'h99) begin errors++; $display("FAIL stall_go got %0h/%0h want 1/99", rob_commit, rob_result); end
    idle(); rdy_in = 0; cycle();
    checks++; if (rob_commit !== 1'b1) begin errors++; $display("FAIL stall_hold got %0h want 1", rob_commit); end
    idle(); cycle();
    checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL stall_release got %0h want 0", rob_commit); end
  endtask

  task automatic test_query();
    reset_dut();
    for (int i = 0; i < 2; i++) begin idle(); new_issue = 1; cycle(); end
    idle(); rs_broadcast = 1; rs_entry = 5'd2; rs_result = 32'h55; query_j = 5'd2; query_k = 5'd0; #1;
    checks++; if (query_j_ready !== 1'b0) begin errors++; $display("FAIL query_bypass got %0h want 0", query_j_ready); end
    checks++; if (query_k_ready !== 1'b0 || query_k_value !== 32'd0) begin errors++; $display("FAIL query_null got %0h/%0h want 0/0", query_k_ready, query_k_value); end
    cycle();
    idle(); query_j = 5'd2; query_k = 5'd1; #1;
    checks++; if (query_j_ready !== 1'b1 || query_j_value !== 32'h55) begin errors++; $display("FAIL query_hit got %0h/%0h want 1/55", query_j_ready, query_j_value); end
    checks++; if (query_k_ready !== 1'b0) begin errors++; $display("FAIL query_pending got %0h want 0", query_k_ready); end
  endtask

  task automatic test_random();
    int k;
    bit jr, kr;
    logic [31:0] jv, kv;
    reset_dut();
    for (int it = 0; it < 800; it++) begin
      idle();
      rdy_in = $urandom_range(0, 7) != 0;
      new_issue = $urandom_range(0, 2) != 0;
      issue_type = 2'($urandom_range(0, 2));
      issue_rd = 6'($urandom); issue_pred_pc = $urandom;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, q.size() - 1);
        rs_broadcast = 1; rs_entry = 5'(q[k].tag); rs_result = $urandom;
        rs_next_pc = $urandom_range(0, 7) == 0 ? $urandom : q[k].pred;
      end else if ($urandom_range(0, 3) == 0) begin
        rs_broadcast = 1; rs_entry = 5'($urandom); rs_result = $urandom; rs_next_pc = $urandom;
      end
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        lsb_broadcast = 1; lsb_entry = 5'(q[$urandom_range(0, q.size() - 1)].tag); lsb_result = $urandom;
      end else if ($urandom_range(0, 5) == 0) begin
        lsb_broadcast = 1; lsb_entry = 5'($urandom); lsb_result = $urandom;
      end
      query_j = q.size() > 0 && $urandom_range(0, 1) == 1 ? 5'(q[$urandom_range(0, q.size() - 1)].tag) : 5'($urandom);
      query_k = q.size() > 0 && $urandom_range(0, 1) == 1 ? 5'(q[$urandom_range(0, q.size() - 1)].tag) : 5'($urandom);
      #1;
      jr = 0; jv = 0; kr = 0; kv = 0;
      foreach (q[i]) begin
        if (q[i].rdy && q[i].tag == int'(query_j)) begin jr = 1; jv = q[i].val; end
        if (q[i].rdy && q[i].tag == int'(query_k)) begin kr = 1; kv = q[i].val; end
      end
      checks++; if (rob_full !== (q.size() == 16) || rob_new_entry !== 5'(m_tail + 1)) begin
        errors++; $display("FAIL rnd_alloc it%0d got %0h/%0h want %0h/%0h", it, rob_full, rob_new_entry, q.size() == 16, m_tail + 1);
      end
      checks++; if (query_j_ready !== jr || query_j_value !== jv) begin
        errors++; $display("FAIL rnd_qj it%0d got %0h/%0h want %0h/%0h", it, query_j_ready, query_j_value, jr, jv);
      end
      checks++; if (query_k_ready !== kr || query_k_value !== kv) begin
        errors++; $display("FAIL rnd_qk it%0d got %0h/%0h want %0h/%0h", it, query_k_ready, query_k_value, kr, kv);
      end
      cycle();
      checks++; if (rob_commit !== e_commit || store_commit !== e_store || roll_back !== e_rb) begin
        errors++; $display("FAIL rnd_pulse it%0d got %0h/%0h/%0h want %0h/%0h/%0h", it, rob_commit, store_commit, roll_back, e_commit, e_store, e_rb);
      end
      checks++; if (rob_entry !== e_entry || rob_des !== e_des || rob_result !== e_result || roll_back_pc !== e_rb_pc) begin
        errors++; $display("FAIL rnd_data it%0d got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h", it, rob_entry, rob_des, rob_result, roll_back_pc, e_entry, e_des, e_result, e_rb_pc);
      end
    end
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_store();
    test_rdy_stall();
    test_query();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the Tomasulo core.
- Allocates a tag per issued instruction and captures results from the RS and LSB broadcast buses.
- Forwards ready values to dispatch operand lookup.
- Retires one instruction per cycle from the head and drives the commit and roll-back interface consumed by the register file, LSB and fetch.

Parameters:
- ENTRY_SIZE, 4, log2 of entry count; ROB_SIZE = 2^ENTRY_SIZE = 16.
- Tag width is ENTRY_SIZE+1 bits. Slot i carries tag i+1; tag 0 is ENTRY_NULL.

Ports:
- clk  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low freezes all state and all outputs
- new_issue  in  1  allocate an entry this cycle
- issue_type  in  2  0 = ALU/load, 1 = branch/jump, 2 = store
- issue_rd  in  6  destination register; 0 means none
- issue_pred_pc  in  32  predicted next PC
- rob_new_entry  out  5  tag the next issue receives (combinational, = tail+1)
- rob_full  out  1  count == ROB_SIZE (combinational)
- rs_broadcast  in  1  RS result valid
- rs_entry  in  5  RS result tag
- rs_result  in  32  RS result value
- rs_next_pc  in  32  actual next PC (meaningful for type 1 only)
- lsb_broadcast  in  1  LSB result valid
- lsb_entry  in  5  LSB result tag
- lsb_result  in  32  LSB result value
- query_j  in  5  operand lookup tag
- query_k  in  5  operand lookup tag
- query_j_ready  out  1  lookup hit, entry ready
- query_k_ready  out  1  lookup hit, entry ready
- query_j_value  out  32  ready value
- query_k_value  out  32  ready value
- rob_commit  out  1  registered commit pulse
- rob_entry  out  5  committed tag
- rob_des  out  6  committed rd
- rob_result  out  32  committed value
- store_commit  out  1  registered pulse when the committed entry is a store
- roll_back  out  1  registered misprediction flush pulse
- roll_back_pc  out  32  redirect PC

Behaviour:
- Reset: head = tail = count = 0; all valid/ready bits clear.
- Reset output values: rob_commit = 0, store_commit = 0, roll_back = 0; rob_entry = 0, rob_des = 0, rob_result = 0, roll_back_pc = 0.
- rdy_in low: nothing updates and registered outputs hold. A held pulse is consumed exactly once at the next active edge, because consumers freeze identically.
- Issue: when new_issue && !rob_full, the slot at tail takes type, rd, pred_pc, ready = 0. Tail increments modulo ROB_SIZE. A new_issue while full is ignored; the issuer must gate on rob_full.
- Broadcast: a valid tag writes the value and sets ready; RS additionally writes the actual next PC. RS and LSB targeting different tags both apply in the same cycle.
  - A broadcast to tag 0 or to an invalid slot is ignored.
  - Same tag on both buses: the LSB write wins.
- Query: combinational read of registered state only; no bypass of same-cycle broadcasts. Tag 0 returns ready = 0, value = 0.
- Commit: each active edge, if the head slot is valid and its registered ready bit is set:
  - rob_commit = 1; rob_entry = head tag; rob_des = rd (0 for stores and branches without rd); rob_result = value.
  - Free the slot and increment head.
  - Otherwise rob_commit = 0 and store_commit = 0 next cycle.
  - Minimum latency: broadcast sampled at edge M → rob_commit high after edge M+1.
- Store commit: type 2 also pulses store_commit with the same tag.
- Misprediction: committing type 1 with next_pc != pred_pc asserts roll_back = 1 and roll_back_pc = next_pc in the same cycle as rob_commit. The jump's rd value still commits.
  - In that same edge all slots clear, head = tail = count = 0, and a simultaneous issue is discarded.
  - roll_back deasserts the following cycle unless another mispredict occurs.
- Count: +1 on accepted issue, −1 on commit, both in one cycle → unchanged. Wrap-around from slot 15 to 0 is transparent to tags.
- Commit and issue in the same cycle while full: issue is still rejected (full is evaluated before commit).

Test Plan:
1. Reset, issue tags 1, 2, 3 (rd 5, 6, 7); broadcast in order 3, 1, 2 (values 0x30, 0x10, 0x20) → commits in order tag 1/rd5/0x10, then 2/rd6/0x20, then 3/rd7/0x30 on consecutive cycles.
2. Issue 16 entries → rob_full = 1 and the 17th issue is ignored. Commit one → full clears; the next issue gets tag 1 (wrap-around).
3. Branch tag 1 with pred_pc 0x104, RS next_pc 0x200; younger tags 2 and 3 issued → on commit, roll_back = 1, roll_back_pc = 0x200, count = 0, and the next rob_new_entry is 1.
4. Store tag 1, LSB broadcast → rob_commit and store_commit pulse together with rob_des = 0.
5. rdy_in low for 3 cycles while tag 1 is ready → no commit; rob_commit is asserted at the first edge with rdy_in high.
6. Query tag 2 in the same cycle as its broadcast → ready = 0; query next cycle → ready = 1 with the broadcast value. Query tag 0 → ready = 0, value = 0.
